// File: rtl/rsa_modexp_param.sv
// Montgomery modular exponentiation core: o_a_pow_d = i_a^i_d mod i_n.
// The pre-stage converts the base into the Montgomery domain (a*2^W mod n).
// Per exponent bit, two bit-serial Montgomery multipliers run side by side
// (square and multiply). The running product m stays in the normal domain
// because Mont(m, t) with t = a^(2^k)*2^W cancels the 2^W factor.
module rsa_modexp_param #(
    parameter int W  = 256,
    parameter int CW = $clog2(W) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_d,
    input  logic [W-1:0]  i_n,
    input  logic [CW-1:0] i_ebits,
    output logic          o_busy,
    output logic [W-1:0]  o_a_pow_d,
    output logic          o_finished
);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_MONT, S_UPD, S_DONE} state_t;

    localparam logic [CW-1:0] W_C   = CW'(W);
    localparam logic [CW-1:0] W_M1  = CW'(W - 1);
    localparam logic [CW-1:0] K_ONE = CW'(1);

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, r_k, r_e;
    logic [W-1:0]    r_n, r_d, r_pt, r_t, r_m, r_ts, r_ms, r_result;
    logic [W+1:0]    r_rt, r_rm;
    logic            r_finished;

    logic [W-1:0]    w_pt_dbl, w_t_acc;
    logic [W+1:0]    w_rt_step, w_rm_step;
    logic [CW-1:0]   w_k_inc;

    // Single conditional subtraction; callers guarantee x < 2n for valid operands
    function automatic logic [W-1:0] f_reduce(input logic [W+1:0] x, input logic [W-1:0] n);
        return W'((x >= {2'b00, n}) ? (x - {2'b00, n}) : x);
    endfunction

    // One Montgomery step: r = (r + abit*b + q*n) / 2 with q making the sum even
    function automatic logic [W+1:0] f_mont_step(input logic [W+1:0] r, input logic abit,
                                                 input logic [W-1:0] b, input logic [W-1:0] n);
        logic [W+1:0] s;
        s = r + (abit ? {2'b00, b} : '0);
        if (s[0]) s = s + {2'b00, n};
        return {1'b0, s[W+1:1]};
    endfunction

    assign w_pt_dbl  = f_reduce({1'b0, r_pt, 1'b0}, r_n);
    assign w_t_acc   = f_reduce({2'b00, r_t} + {2'b00, r_pt}, r_n);
    assign w_rt_step = f_mont_step(r_rt, r_ts[0], r_t, r_n);
    assign w_rm_step = f_mont_step(r_rm, r_ms[0], r_t, r_n);
    assign w_k_inc   = r_k + K_ONE;

    assign o_busy     = (r_state != S_IDLE);
    assign o_a_pow_d  = r_result;
    assign o_finished = r_finished;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode: PREP W+1 cycles, MONT W cycles, UPD and DONE one each
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_PREP;
            S_PREP:  if (r_cnt == W_C) w_state_next = S_MONT;
            S_MONT:  if (r_cnt == W_M1) w_state_next = S_UPD;
            S_UPD:   w_state_next = (w_k_inc == r_e) ? S_DONE : S_MONT;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand latch, a*2^W pre-stage, the two multipliers and the exponent walk
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0; r_k <= '0; r_e <= '0;
            r_n <= '0; r_d <= '0; r_pt <= '0; r_t <= '0; r_m <= '0;
            r_ts <= '0; r_ms <= '0; r_result <= '0;
            r_rt <= '0; r_rm <= '0; r_finished <= 1'b0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_n   <= i_n;
                        r_d   <= i_d;
                        r_e   <= (i_ebits == '0) ? W_C : i_ebits;
                        r_pt  <= i_a;
                        r_t   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_PREP: begin
                    // Multiplier is the constant 2^W: only its top bit adds into t
                    r_pt <= w_pt_dbl;
                    if (r_cnt == W_C) begin
                        r_t   <= w_t_acc;
                        r_ts  <= w_t_acc;
                        r_m   <= W'(1);
                        r_ms  <= W'(1);
                        r_rt  <= '0;
                        r_rm  <= '0;
                        r_k   <= '0;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + K_ONE;
                    end
                end
                S_MONT: begin
                    r_ts <= r_ts >> 1;
                    r_ms <= r_ms >> 1;
                    if (r_cnt == W_M1) begin
                        r_rt  <= {2'b00, f_reduce(w_rt_step, r_n)};
                        r_rm  <= {2'b00, f_reduce(w_rm_step, r_n)};
                        r_cnt <= '0;
                    end else begin
                        r_rt  <= w_rt_step;
                        r_rm  <= w_rm_step;
                        r_cnt <= r_cnt + K_ONE;
                    end
                end
                S_UPD: begin
                    r_t  <= r_rt[W-1:0];
                    r_ts <= r_rt[W-1:0];
                    if (r_d[0]) begin
                        r_m  <= r_rm[W-1:0];
                        r_ms <= r_rm[W-1:0];
                    end else begin
                        r_ms <= r_m;
                    end
                    r_d  <= r_d >> 1;
                    r_k  <= w_k_inc;
                    r_rt <= '0;
                    r_rm <= '0;
                end
                S_DONE: begin
                    r_result   <= r_m;
                    r_finished <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_param.sv
// Directed and random checks for rsa_modexp_param at W=8 and W=16.
// Every accepted start pushes the expected result and latency into a queue;
// each o_finished pulse pops and compares against it.
module tb_rsa_modexp_param;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;

    logic        start8, busy8, fin8;
    logic [7:0]  a8, d8, n8, res8;
    logic [3:0]  e8;

    logic        start16, busy16, fin16;
    logic [15:0] a16, d16, n16, res16;
    logic [4:0]  e16;

    typedef struct {
        longint unsigned res;
        int              s;
        int              lat;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   acc8 = 0, acc16 = 0, done8 = 0, done16 = 0, drop8 = 0, drop16 = 0;
    int   errors = 0, checks = 0;

    rsa_modexp_param #(.W(8)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_d(d8), .i_n(n8),
        .i_ebits(e8), .o_busy(busy8), .o_a_pow_d(res8), .o_finished(fin8)
    );

    rsa_modexp_param #(.W(16)) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_start(start16), .i_a(a16), .i_d(d16), .i_n(n16),
        .i_ebits(e16), .o_busy(busy16), .o_a_pow_d(res16), .o_finished(fin16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden model: plain square-and-multiply over the first e exponent bits
    function automatic longint unsigned modexp(input longint unsigned a, input longint unsigned d,
                                               input longint unsigned n, input int e);
        longint unsigned r, b;
        r = 1;
        b = a % n;
        for (int i = 0; i < e; i++) begin
            if (d[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample completions/acceptances on the falling edge, return 1ns after the rising edge.
    // Latency is the count of edges from the start-sampling edge to the first edge that
    // can sample o_finished high.
    task automatic tick();
        int e;
        exp_t x;
        @(negedge clk);
        if (rst) begin
            drop8  += q8.size();
            drop16 += q16.size();
            q8.delete();
            q16.delete();
        end else begin
            if (fin8) begin
                done8++;
                chk("fin8_has_pending", 64'(q8.size() > 0), 64'(1));
                chk("busy8_low_at_fin", 64'(busy8), 64'(0));
                if (q8.size() > 0) begin
                    x = q8.pop_front();
                    chk("result8", 64'(res8), x.res);
                    chk("latency8", 64'(cyc + 1 - x.s), 64'(x.lat));
                end
            end
            if (start8 && !busy8) begin
                e = (e8 == 4'd0) ? 8 : int'(e8);
                q8.push_back('{modexp(64'(a8), 64'(d8), 64'(n8), e), cyc + 1, 9 * (e + 1) + 2});
                acc8++;
            end
            if (fin16) begin
                done16++;
                chk("fin16_has_pending", 64'(q16.size() > 0), 64'(1));
                chk("busy16_low_at_fin", 64'(busy16), 64'(0));
                if (q16.size() > 0) begin
                    x = q16.pop_front();
                    chk("result16", 64'(res16), x.res);
                    chk("latency16", 64'(cyc + 1 - x.s), 64'(x.lat));
                end
            end
            if (start16 && !busy16) begin
                e = (e16 == 5'd0) ? 16 : int'(e16);
                q16.push_back('{modexp(64'(a16), 64'(d16), 64'(n16), e), cyc + 1, 17 * (e + 1) + 2});
                acc16++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_op8(input logic [7:0] a, input logic [7:0] d, input logic [7:0] n,
                             input logic [3:0] e);
        a8 = a; d8 = d; n8 = n; e8 = e;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int g;
        g = 0;
        while ((busy8 || busy16 || q8.size() != 0 || q16.size() != 0) && g < limit) begin
            tick();
            g++;
        end
        chk("idle_within_budget", 64'(g < limit), 64'(1));
    endtask

    task automatic rand_ops(input bit wide);
        if (!wide) begin
            n8 = 8'($urandom_range(3, 255) | 1);
            a8 = 8'($urandom_range(0, int'(n8) - 1));
            d8 = 8'($urandom);
            e8 = 4'($urandom_range(0, 8));
        end else begin
            n16 = 16'($urandom_range(3, 65535) | 1);
            a16 = 16'($urandom_range(0, int'(n16) - 1));
            d16 = 16'($urandom);
            e16 = 5'($urandom_range(0, 16));
        end
    endtask

    // Hold start high; churn=1 changes operands every cycle, churn=0 only after each acceptance
    task automatic stream(input bit wide, input int nops, input bit churn);
        int target, last, guard, cur;
        rand_ops(wide);
        if (wide) start16 = 1'b1; else start8 = 1'b1;
        last   = wide ? acc16 : acc8;
        target = last + nops;
        guard  = 0;
        cur    = last;
        while (cur < target && guard < 20000) begin
            tick();
            guard++;
            cur = wide ? acc16 : acc8;
            if (churn || cur != last) rand_ops(wide);
            last = cur;
        end
        start8  = 1'b0;
        start16 = 1'b0;
        chk(wide ? "stream16_accepts" : "stream8_accepts", 64'(cur), 64'(target));
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; d8 = '0; n8 = '0; e8 = '0;
        start16 = 1'b0; a16 = '0; d16 = '0; n16 = '0; e16 = '0;
        tick();
        tick();
        chk("reset_busy8", 64'(busy8), 64'(0));
        chk("reset_fin8", 64'(fin8), 64'(0));
        chk("reset_res8", 64'(res8), 64'(0));
        chk("reset_busy16", 64'(busy16), 64'(0));
        chk("reset_fin16", 64'(fin16), 64'(0));
        chk("reset_res16", 64'(res16), 64'(0));
        rst = 1'b0;
        tick();

        // T1: 5^3 mod 33, full exponent length
        start_op8(8'd5, 8'd3, 8'd33, 4'd0);
        wait_idle(200);
        chk("t1_result", 64'(res8), 64'(26));

        // T2: only the two low exponent bits count
        start_op8(8'd7, 8'hFF, 8'd33, 4'd2);
        wait_idle(200);
        chk("t2_result", 64'(res8), 64'(13));

        // T5: reset in the middle of MONT aborts and clears outputs
        start_op8(8'd5, 8'd3, 8'd33, 4'd0);
        repeat (14) tick();
        rst = 1'b1;
        #1;
        chk("t5_busy_cleared", 64'(busy8), 64'(0));
        chk("t5_fin_low", 64'(fin8), 64'(0));
        chk("t5_res_cleared", 64'(res8), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        start_op8(8'd5, 8'd3, 8'd33, 4'd0);
        wait_idle(200);
        chk("t5_restart_result", 64'(res8), 64'(26));

        // T3: zero exponent gives 1, zero base gives 0
        start_op8(8'd9, 8'd0, 8'd35, 4'd0);
        wait_idle(200);
        chk("t3_d0", 64'(res8), 64'(1));
        start_op8(8'd0, 8'd5, 8'd35, 4'd0);
        wait_idle(200);
        chk("t3_a0", 64'(res8), 64'(0));
        start_op8(8'd9, 8'd0, 8'd35, 4'd3);
        wait_idle(200);
        chk("t3_d0_short", 64'(res8), 64'(1));

        // T4: start held high with operands changing every cycle while busy
        stream(1'b0, 4, 1'b1);
        wait_idle(1000);

        // T6: back-to-back random operations on the wider core
        stream(1'b1, 30, 1'b0);
        wait_idle(1000);

        chk("completions8", 64'(done8 + drop8), 64'(acc8));
        chk("completions16", 64'(done16 + drop16), 64'(acc16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
